dma_bus_arbiter: RTL and testbench

Sequences the shared 16-bit memory bus between the CPU and the DMA engine. Issues the one-cycle DMA start command, resolves the DMA's bus request (BR) against any in-flight CPU memory access, and drives bus grant (BG) and the CPU stall. Reports completion to the CPU with a one-cycle interrupt pulse. Sits between the CPU core, the DMA, and the memory port mux.

---
 rtl/dma_bus_arbiter_pkg.sv | 17 +
 rtl/arb_holdoff_timer.sv | 42 ++++
 rtl/dma_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg
// Shared definitions for the CPU/DMA memory bus arbiter.
//   ARB_WORD_SIZE : data/counter width shared by the CPU, the DMA and the arbiter
//   arb_state_e   : arbiter FSM state encoding
package dma_bus_arbiter_pkg;

    localparam int ARB_WORD_SIZE = 16;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_WAIT_CPU = 3'd1,
        ARB_GRANT    = 3'd2,
        ARB_RELEASE  = 3'd3,
        ARB_HOLDOFF  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_holdoff_timer.sv
// arb_holdoff_timer
// Loadable down-counter with a zero flag. Counting stops at zero.
// Ports:
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one (no effect at zero)
//   zero_o     : counter is zero
module arb_holdoff_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
// Arbitrates the shared memory bus between the CPU and the DMA engine:
// issues the DMA start pulse, grants the bus on BR once the CPU has no
// access in flight, reports completion, and keeps a minimum CPU ownership
// gap after each grant.
//
// Optional feature: define ARB_WATCHDOG_EN to limit a grant to MAX_GRANT
// cycles; an overrun forces release, sets the sticky bus_error and blocks
// further grants until reset. Without it bus_error is always 0.
//
// Ports:
//   CLK          : system clock
//   reset_n      : asynchronous active-low reset
//   dma_start    : CPU request to start a DMA transfer (level)
//   cpu_mem_busy : CPU memory access outstanding this cycle
//   BR           : bus request from DMA
//   cmd          : one-cycle DMA start pulse
//   BG           : bus grant to DMA (registered)
//   cpu_stall    : CPU must not start a new memory access
//   dma_done     : one-cycle completion pulse
//   xfer_count   : grant cycles of the last/current transfer (saturating)
//   bus_error    : sticky watchdog error
//
// state        | meaning
// ARB_IDLE     | CPU owns the bus; may issue cmd or accept BR
// ARB_WAIT_CPU | BR pending, waiting for the CPU access to finish
// ARB_GRANT    | DMA owns the bus, BG=1, counting grant cycles
// ARB_RELEASE  | grant removed, dma_done pulse
// ARB_HOLDOFF  | guaranteed CPU ownership window, BR ignored
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = ARB_WORD_SIZE,
    parameter int MIN_CPU_GAP = 2,
    parameter int MAX_GRANT   = 16
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 dma_start,
    input  logic                 cpu_mem_busy,
    input  logic                 BR,
    output logic                 cmd,
    output logic                 BG,
    output logic                 cpu_stall,
    output logic                 dma_done,
    output logic [WORD_SIZE-1:0] xfer_count,
    output logic                 bus_error
);

    // Timer is loaded with GAP-1 so that its zero flag marks the last
    // holdoff cycle; HOLDOFF then lasts exactly MIN_CPU_GAP cycles.
    localparam logic [WORD_SIZE-1:0] GAP_LOAD =
        (MIN_CPU_GAP > 0) ? WORD_SIZE'(MIN_CPU_GAP - 1) : '0;

    arb_state_e           state_q, state_d;
    logic                 cmd_q, cmd_d;
    logic                 bg_q, bg_d;
    logic                 done_q, done_d;
    logic                 start_spent_q, start_spent_d;
    logic [WORD_SIZE-1:0] xfer_count_q, xfer_count_d;
    logic                 bus_error_q, bus_error_d;
    logic                 br_eff;
    logic                 wd_trip;
    logic                 gap_load, gap_dec, gap_zero;

`ifdef ARB_WATCHDOG_EN
    localparam logic [WORD_SIZE-1:0] GRANT_LAST = WORD_SIZE'(MAX_GRANT - 1);

    // Trip on the cycle that would make the grant MAX_GRANT cycles long.
    assign wd_trip = (state_q == ARB_GRANT) && BR && (xfer_count_q == GRANT_LAST);
    assign br_eff  = BR && !bus_error_q;
`else
    logic [WORD_SIZE-1:0] unused_max_grant;
    assign unused_max_grant = WORD_SIZE'(MAX_GRANT);
    assign wd_trip = 1'b0;
    assign br_eff  = BR;
`endif

    arb_holdoff_timer #(
        .WIDTH (WORD_SIZE)
    ) u_holdoff_timer (
        .clk_i      (CLK),
        .rst_n_i    (reset_n),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = 1'b0;
        xfer_count_d = xfer_count_q;
        bus_error_d  = bus_error_q;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;
        // One start pulse per IDLE visit: re-armed by leaving IDLE.
        start_spent_d = (state_q == ARB_IDLE) ? start_spent_q : 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (br_eff) begin
                    state_d = cpu_mem_busy ? ARB_WAIT_CPU : ARB_GRANT;
                end else if (dma_start && !start_spent_q) begin
                    cmd_d         = 1'b1;
                    start_spent_d = 1'b1;
                end
            end
            ARB_WAIT_CPU: begin
                if (!BR) begin
                    state_d = ARB_IDLE;
                end else if (!cpu_mem_busy) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                xfer_count_d = (xfer_count_q == '1) ? xfer_count_q : xfer_count_q + 1'b1;
                if (!BR) begin
                    state_d = ARB_RELEASE;
                end else if (wd_trip) begin
                    state_d     = ARB_RELEASE;
                    bus_error_d = 1'b1;
                end
            end
            ARB_RELEASE: begin
                if (MIN_CPU_GAP > 0) begin
                    state_d  = ARB_HOLDOFF;
                    gap_load = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_HOLDOFF: begin
                if (gap_zero) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if ((state_d == ARB_GRANT) && (state_q != ARB_GRANT)) begin
            xfer_count_d = '0;
        end

        bg_d   = (state_d == ARB_GRANT);
        // A watchdog-forced release is not a completion.
        done_d = (state_d == ARB_RELEASE) && !bus_error_d;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            cmd_q         <= 1'b0;
            bg_q          <= 1'b0;
            done_q        <= 1'b0;
            start_spent_q <= 1'b0;
            xfer_count_q  <= '0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bg_q          <= bg_d;
            done_q        <= done_d;
            start_spent_q <= start_spent_d;
            xfer_count_q  <= xfer_count_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign cmd        = cmd_q;
    assign BG         = bg_q;
    assign dma_done   = done_q;
    assign xfer_count = xfer_count_q;
    assign bus_error  = bus_error_q;
    // Combinational so the CPU is held off in the very cycle BR is first seen.
    assign cpu_stall  = (state_q == ARB_WAIT_CPU) || (state_q == ARB_GRANT) ||
                        ((state_q == ARB_IDLE) && br_eff);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;

    localparam int WORD_SIZE   = 16;
    localparam int MIN_CPU_GAP = 2;
    localparam int MAX_GRANT   = 16;
    localparam int COUNT_MAX   = 65535;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 reset_n;
    logic                 dma_start;
    logic                 cpu_mem_busy;
    logic                 BR;
    logic                 cmd;
    logic                 BG;
    logic                 cpu_stall;
    logic                 dma_done;
    logic [WORD_SIZE-1:0] xfer_count;
    logic                 bus_error;

    int n_checks = 0;
    int n_errors = 0;
    int cmd_cnt  = 0;
    int done_cnt = 0;
    int bg_cnt   = 0;
    int bg0, d0;
    bit cmp_en   = 1'b0;

    dma_bus_arbiter #(
        .WORD_SIZE   (WORD_SIZE),
        .MIN_CPU_GAP (MIN_CPU_GAP),
        .MAX_GRANT   (MAX_GRANT)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .dma_start    (dma_start),
        .cpu_mem_busy (cpu_mem_busy),
        .BR           (BR),
        .cmd          (cmd),
        .BG           (BG),
        .cpu_stall    (cpu_stall),
        .dma_done     (dma_done),
        .xfer_count   (xfer_count),
        .bus_error    (bus_error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Behavioural model: who owns the bus, how long the DMA has held it,
    // how much CPU guard time remains, and whether the start pulse is used up.
    bit m_wait, m_own, m_rel, m_err, m_cmd, m_spent, m_idle, m_trip;
    int m_gap, m_count;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_wait = 0; m_own = 0; m_rel = 0; m_err = 0; m_cmd = 0; m_spent = 0;
            m_gap = 0; m_count = 0;
        end else begin
            m_idle = !m_wait && !m_own && !m_rel && (m_gap == 0);
            m_cmd  = m_idle && dma_start && !(BR && !m_err) && !m_spent;
            if (!m_idle)    m_spent = 0;
            else if (m_cmd) m_spent = 1;
            if (m_own) begin
                m_count++;
                m_trip = WD && BR && (m_count >= MAX_GRANT);
                if (!BR || m_trip) begin
                    m_own = 0;
                    m_rel = 1;
                    if (m_trip) m_err = 1;
                end
            end else if (m_rel) begin
                m_rel = 0;
                m_gap = MIN_CPU_GAP;
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (m_wait) begin
                if (!BR) m_wait = 0;
                else if (!cpu_mem_busy) begin
                    m_wait = 0; m_own = 1; m_count = 0;
                end
            end else if (BR && !m_err) begin
                if (cpu_mem_busy) m_wait = 1;
                else begin
                    m_own = 1; m_count = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cmd", int'(cmd), int'(m_cmd));
            check("BG", int'(BG), int'(m_own));
            check("dma_done", int'(dma_done), int'(m_rel && !m_err));
            check("xfer_count", int'(xfer_count), (m_count > COUNT_MAX) ? COUNT_MAX : m_count);
            check("cpu_stall", int'(cpu_stall),
                  int'(m_wait || m_own ||
                       (!m_rel && (m_gap == 0) && BR && !m_err)));
            check("bus_error", int'(bus_error), int'(m_err));
            check("bg_with_busy", int'(BG && cpu_mem_busy), 0);
            if (cmd)      cmd_cnt++;
            if (dma_done) done_cnt++;
            if (BG)       bg_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; dma_start = 1'b0; cpu_mem_busy = 1'b0; BR = 1'b1;
        cmp_en = 1'b1;
        cyc(2);
        check("rst_bg", int'(BG), 0);
        check("rst_count", int'(xfer_count), 0);
        check("rst_stall_follows_br", int'(cpu_stall), 1);
        BR = 1'b0; reset_n = 1'b1;
        cyc(1);

        // single start pulse
        dma_start = 1'b1; cyc(1);
        check("cmd_pulse", int'(cmd), 1);
        dma_start = 1'b0; cyc(1);
        check("cmd_low", int'(cmd), 0);
        cyc(2);
        check("cmd_once", cmd_cnt, 1);

        // clean 12-cycle grant, BR re-asserted during holdoff
        BR = 1'b1; #1;
        check("stall_on_br", int'(cpu_stall), 1);
        cyc(1);
        check("bg_after_br", int'(BG), 1);
        cyc(11); BR = 1'b0;
        cyc(1);
        check("done_pulse", int'(dma_done), 1);
        check("bg_released", int'(BG), 0);
        check("burst_count", int'(xfer_count), 12);
        BR = 1'b1;
        cyc(1); check("holdoff_bg1", int'(BG), 0);
        cyc(1); check("holdoff_bg2", int'(BG), 0);
        cyc(1); check("idle_bg", int'(BG), 0);
        cyc(1); check("regrant", int'(BG), 1);
        BR = 1'b0; cyc(6);
        check("done_twice", done_cnt, 2);

        // held start after returning to IDLE: one more pulse only
        dma_start = 1'b1; cyc(5);
        dma_start = 1'b0; cyc(2);
        check("cmd_held_once", cmd_cnt, 2);

        // BR while CPU busy
        cpu_mem_busy = 1'b1; BR = 1'b1; #1;
        check("stall_busy", int'(cpu_stall), 1);
        cyc(3);
        check("bg_wait_busy", int'(BG), 0);
        cpu_mem_busy = 1'b0; cyc(1);
        check("bg_after_busy", int'(BG), 1);
        cyc(3); BR = 1'b0; cyc(6);
        check("busy_count", int'(xfer_count), 4);

        // abort in WAIT_CPU
        bg0 = bg_cnt; d0 = done_cnt;
        cpu_mem_busy = 1'b1; BR = 1'b1; cyc(2);
        BR = 1'b0; cyc(1);
        cpu_mem_busy = 1'b0; cyc(3);
        check("abort_no_bg", bg_cnt - bg0, 0);
        check("abort_no_done", done_cnt - d0, 0);

        // reset in the middle of a grant
        BR = 1'b1; cyc(5);
        check("mid_grant_bg", int'(BG), 1);
        #2 reset_n = 1'b0; #1;
        check("arst_bg", int'(BG), 0);
        check("arst_done", int'(dma_done), 0);
        check("arst_count", int'(xfer_count), 0);
        BR = 1'b0; cyc(1);
        reset_n = 1'b1; cyc(1);
        BR = 1'b1; cyc(4);
        BR = 1'b0; cyc(1);
        check("post_reset_done", int'(dma_done), 1);
        check("post_reset_count", int'(xfer_count), 4);
        cyc(5);

`ifdef ARB_WATCHDOG_EN
        // stuck BR: watchdog cuts the grant at MAX_GRANT cycles
        bg0 = bg_cnt; d0 = done_cnt;
        BR = 1'b1; cyc(25);
        check("wd_bg_cycles", bg_cnt - bg0, 16);
        check("wd_error", int'(bus_error), 1);
        check("wd_no_done", done_cnt - d0, 0);
        check("wd_count", int'(xfer_count), 16);
        check("wd_no_stall", int'(cpu_stall), 0);
        cyc(10);
        check("wd_sticky", int'(bus_error), 1);
        check("wd_no_regrant", bg_cnt - bg0, 16);
        #2 reset_n = 1'b0; #1;
        check("wd_clear", int'(bus_error), 0);
        BR = 1'b0; cyc(1);
        reset_n = 1'b1; cyc(2);
`endif

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
